// File: rtl/sm3_pkg.sv
// Shared SM3 datapath definitions: word width, requester limit and a constant-safe clog2.
package sm3_pkg;

    localparam int SM3_WORD_W  = 32;
    localparam int SM3_MAX_REQ = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sm3_adder.sv
// 3-input mod-2^32 adder shared by the SM3 compression/expansion datapath.
module sm3_adder
    import sm3_pkg::*;
(
    input  logic [SM3_WORD_W-1:0] a_i,
    input  logic [SM3_WORD_W-1:0] b_i,
    input  logic [SM3_WORD_W-1:0] c_i,
    output logic [SM3_WORD_W-1:0] sum_o
);

    // Carry out of the top bit is intentionally dropped.
    assign sum_o = a_i + b_i + c_i;

endmodule

// File: rtl/sm3_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after ptr_i wins.
module sm3_rr_arbiter
    import sm3_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   grant_idx_o
);

    logic           found;
    logic [PTR_W:0] cand;

    // cand is one bit wider so ptr+k never overflows before the modulo wrap.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && req_i[cand[PTR_W-1:0]]) begin
                found       = 1'b1;
                grant_idx_o = cand[PTR_W-1:0];
            end
        end
        if (en_i && found) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/sm3_adder_arbiter.sv
// Round-robin time-sharing of one sm3_adder among NUM_REQ requesters with a tagged response.
// Define SM3_ADDER_ARB_OUTREG_EN for a second output register stage (2-cycle latency).
module sm3_adder_arbiter
    import sm3_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*SM3_WORD_W-1:0] req_a,
    input  logic [NUM_REQ*SM3_WORD_W-1:0] req_b,
    input  logic [NUM_REQ*SM3_WORD_W-1:0] req_c,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [SM3_WORD_W-1:0]         rsp_sum,
    output logic [ID_W-1:0]               rsp_id
);

    localparam int PTR_W = clog2(NUM_REQ);

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_en;
    logic                  xfer;
    logic [SM3_WORD_W-1:0] a_sel, b_sel, c_sel, sum;

    sm3_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .en_i        (grant_en),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign req_ready = grant;
    assign xfer      = |grant;
    assign a_sel     = req_a[grant_idx*SM3_WORD_W +: SM3_WORD_W];
    assign b_sel     = req_b[grant_idx*SM3_WORD_W +: SM3_WORD_W];
    assign c_sel     = req_c[grant_idx*SM3_WORD_W +: SM3_WORD_W];

    sm3_adder u_add (
        .a_i   (a_sel),
        .b_i   (b_sel),
        .c_i   (c_sel),
        .sum_o (sum)
    );

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

`ifdef SM3_ADDER_ARB_OUTREG_EN
    logic                  s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [SM3_WORD_W-1:0] s1_sum_q, s1_sum_d, s2_sum_q, s2_sum_d;
    logic [ID_W-1:0]       s1_id_q, s1_id_d, s2_id_q, s2_id_d;
    logic                  s2_free;

    assign s2_free  = !s2_valid_q || rsp_ready;
    assign grant_en = !s1_valid_q || s2_free;

    // Two-entry pipeline: stage 2 drains first, stage 1 refills behind it.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_id_d    = s2_id_q;
        if (s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_d = s1_sum_q;
                s2_id_d  = s1_id_q;
            end
        end
        if (grant_en) begin
            s1_valid_d = xfer;
            if (xfer) begin
                s1_sum_d = sum;
                s1_id_d  = ID_W'(grant_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_id_q    <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_id_q    <= s2_id_d;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_sum   = s2_sum_q;
    assign rsp_id    = s2_id_q;
`else
    logic                  rsp_valid_q, rsp_valid_d;
    logic [SM3_WORD_W-1:0] rsp_sum_q, rsp_sum_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;

    assign grant_en = !rsp_valid_q || rsp_ready;

    // A new grant overwrites a retiring response in the same cycle, so no bubble.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        if (xfer) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = sum;
            rsp_id_d    = ID_W'(grant_idx);
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
`endif

endmodule

// File: tb/tb_sm3_adder_arbiter.sv
// Self-checking bench for sm3_adder_arbiter: directed vectors, corner sequences and a random run.
module tb_sm3_adder_arbiter;

`ifdef SM3_ADDER_ARB_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*32-1:0] req_a = '0, req_b = '0, req_c = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_sum;
    logic [1:0]    rsp_id;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          port;
        logic [31:0] a, b, c, sum;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        int          id;
        int          t;
    } item_t;

    vec_t  vecs[5];
    item_t q[$];

    sm3_adder_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setOperands(input int port, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        req_a[port*32 +: 32] = a;
        req_b[port*32 +: 32] = b;
        req_c[port*32 +: 32] = c;
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        nextCycle();
        setOperands(v.port, v.a, v.b, v.c);
        req_valid = N'(1) << v.port;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("vec_ready", req_ready, 32'(1) << v.port);
        checkOutput("vec_idle_valid", rsp_valid, 0);
        nextCycle();
        req_valid = '0;
        repeat (LAT-1) begin
            @(negedge clk);
            checkOutput("vec_latency_valid", rsp_valid, 0);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("vec_valid", rsp_valid, 1);
        checkOutput("vec_sum", rsp_sum, v.sum);
        checkOutput("vec_id", rsp_id, v.port);
        nextCycle();
        @(negedge clk);
        checkOutput("vec_retired", rsp_valid, 0);
        checkOutput("vec_sum_hold", rsp_sum, v.sum);
        checkOutput("vec_id_hold", rsp_id, v.port);
    endtask

    initial begin
        logic [31:0] ra[N], rb[N], rc[N];
        logic [N-1:0] rv;
        int mptr, g, hid;
        logic vis, free;

        vecs[0] = '{port: 2, a: 32'h00000001, b: 32'h00000002, c: 32'h00000003, sum: 32'h00000006};
        vecs[1] = '{port: 0, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, c: 32'hFFFFFFFF, sum: 32'hFFFFFFFD};
        vecs[2] = '{port: 1, a: 32'h80000000, b: 32'h80000000, c: 32'h00000001, sum: 32'h00000001};
        vecs[3] = '{port: 3, a: 32'h12345678, b: 32'h11111111, c: 32'h00000000, sum: 32'h23456789};
        vecs[4] = '{port: 2, a: 32'hDEADBEEF, b: 32'h00000001, c: 32'h21524110, sum: 32'h00000000};

        doReset();
        @(negedge clk);
        checkOutput("reset_valid", rsp_valid, 0);
        checkOutput("reset_sum", rsp_sum, 0);
        checkOutput("reset_id", rsp_id, 0);
        checkOutput("reset_ready", req_ready, 0);

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

        // All ports busy: strict 0,1,2,3 rotation with back-to-back responses.
        doReset();
        nextCycle();
        for (int i = 0; i < N; i++) setOperands(i, 32'(i + 1), 32'h10, 32'h100);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("rr_ready", req_ready, 32'(1) << (k % N));
            if (k >= LAT) begin
                checkOutput("rr_valid", rsp_valid, 1);
                checkOutput("rr_id", rsp_id, (k - LAT) % N);
                checkOutput("rr_sum", rsp_sum, 32'h111 + 32'((k - LAT) % N));
            end else begin
                checkOutput("rr_valid_fill", rsp_valid, 0);
            end
            nextCycle();
        end

        hid = (8 - LAT) % N;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            checkOutput("stall_ready", req_ready, 0);
            checkOutput("stall_valid", rsp_valid, 1);
            checkOutput("stall_id", rsp_id, hid);
            checkOutput("stall_sum", rsp_sum, 32'h111 + 32'(hid));
            nextCycle();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("unstall_ready", req_ready, 32'b0010);
        checkOutput("unstall_id", rsp_id, hid);
        nextCycle();
        req_valid = '0;
        repeat (3) nextCycle();

        // Port 3 wins, then ports 0 and 3 compete: pointer wraps to 0 first.
        req_valid = 4'b1000;
        @(negedge clk);
        checkOutput("wrap_p3", req_ready, 32'b1000);
        nextCycle();
        req_valid = 4'b1001;
        @(negedge clk);
        checkOutput("wrap_first", req_ready, 32'b0001);
        nextCycle();
        req_valid = 4'b1000;
        @(negedge clk);
        checkOutput("wrap_second", req_ready, 32'b1000);
        nextCycle();
        req_valid = '0;
        repeat (3) nextCycle();

        // Reset while a response is pending, with the pointer left at 3.
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        @(negedge clk);
        checkOutput("mid_grant", req_ready, 32'b0100);
        nextCycle();
        req_valid = '0;
        repeat (LAT-1) nextCycle();
        @(negedge clk);
        checkOutput("mid_pending", rsp_valid, 1);
        nextCycle();
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("mid_valid", rsp_valid, 0);
        checkOutput("mid_sum", rsp_sum, 0);
        checkOutput("mid_id", rsp_id, 0);
        checkOutput("mid_ready", req_ready, 32'b0010);
        nextCycle();
        req_valid = '0;

        // Random traffic against a queue-based model of the response stream.
        doReset();
        rv   = '0;
        mptr = 0;
        q.delete();
        for (int n = 0; n < 400; n++) begin
            nextCycle();
            for (int i = 0; i < N; i++) begin
                if (!rv[i] && $urandom_range(0, 1) == 1) begin
                    rv[i] = 1'b1;
                    ra[i] = $urandom;
                    rb[i] = $urandom;
                    rc[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
                end
                setOperands(i, ra[i], rb[i], rc[i]);
            end
            req_valid = rv;
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            vis  = (q.size() > 0) && (q[0].t + LAT <= n);
            free = (q.size() < LAT) || rsp_ready;
            g = -1;
            if (free) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && rv[(mptr + k) % N]) g = (mptr + k) % N;
                end
            end
            checkOutput("rand_ready", req_ready, (g >= 0) ? (32'(1) << g) : 32'd0);
            checkOutput("rand_valid", rsp_valid, 32'(vis));
            if (vis) begin
                checkOutput("rand_sum", rsp_sum, q[0].sum);
                checkOutput("rand_id", rsp_id, q[0].id);
                if (rsp_ready) void'(q.pop_front());
            end
            if (g >= 0) begin
                q.push_back('{sum: ra[g] + rb[g] + rc[g], id: g, t: n});
                mptr  = (g + 1) % N;
                rv[g] = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
